// File: rtl/sync_fifo_ctrl_if.sv
// sync_fifo_ctrl_if: handshake/status bundle for sync_fifo_ctrl.
//   master: the FIFO user. It drives w_en, data_in, r_en and clr_err.
//   slave : the FIFO itself. It drives the read port, the occupancy count,
//           the status flags and the sticky error flags.
// cnt_width must equal $clog2(depth+1) of the attached FIFO.
interface sync_fifo_ctrl_if #(
   parameter int unsigned data_width = 8,
   parameter int unsigned cnt_width  = 9
);
   logic                  w_en;
   logic [data_width-1:0] data_in;
   logic                  r_en;
   logic [data_width-1:0] data_out;
   logic                  data_valid;
   logic                  full;
   logic                  empty;
   logic                  almost_full;
   logic                  almost_empty;
   logic [cnt_width-1:0]  count;
   logic                  overflow;
   logic                  underflow;
   logic                  clr_err;

   modport master (
      output w_en, data_in, r_en, clr_err,
      input  data_out, data_valid, full, empty, almost_full, almost_empty,
             count, overflow, underflow
   );

   modport slave (
      input  w_en, data_in, r_en, clr_err,
      output data_out, data_valid, full, empty, almost_full, almost_empty,
             count, overflow, underflow
   );
endinterface

// File: rtl/sync_fifo_ctrl.sv
// sync_fifo_ctrl: single-clock FIFO of any depth (non-power-of-two allowed).
// It holds the storage array, the wrapping read and write pointers and the
// occupancy counter. It also provides registered status flags, a registered
// read port with a valid strobe, and sticky overflow/underflow flags.
// Ports:
//   clk  - sole clock, rising edge
//   rst  - asynchronous, active-high reset
//   bus  - sync_fifo_ctrl_if.slave: w_en/data_in write side, r_en/data_out/
//          data_valid read side, full/empty/almost_* flags, count,
//          overflow/underflow sticky errors, clr_err synchronous error clear
// Storage is not reset. Every output is a register, so no combinational path
// runs from a request to an output.
module sync_fifo_ctrl #(
   parameter int unsigned data_width = 8,
   parameter int unsigned depth      = 409,
   parameter int unsigned ptr_width  = $clog2(depth),
   parameter int unsigned cnt_width  = $clog2(depth + 1),
   parameter int unsigned af_thresh  = depth - 4,
   parameter int unsigned ae_thresh  = 4
) (
   input logic             clk,
   input logic             rst,
   sync_fifo_ctrl_if.slave bus
);

   localparam logic [cnt_width-1:0] depth_c = cnt_width'(depth);
   localparam logic [cnt_width-1:0] af_c    = cnt_width'(af_thresh);
   localparam logic [cnt_width-1:0] ae_c    = cnt_width'(ae_thresh);
   localparam logic [ptr_width-1:0] last_c  = ptr_width'(depth - 1);

   logic [data_width-1:0] mem [depth];

   logic [ptr_width-1:0]  wptr_q, rptr_q;
   logic [cnt_width-1:0]  cnt_q, cnt_d;
   logic [data_width-1:0] dout_q;
   logic                  dvalid_q;
   logic                  full_q, empty_q, afull_q, aempty_q;
   logic                  ovf_q, udf_q;
   logic                  wr_acc, rd_acc;

   // Acceptance uses the registered flags from before the edge. When the FIFO
   // is full, wptr == rptr, so only the count tells full and empty apart.
   assign wr_acc = bus.w_en && !full_q;
   assign rd_acc = bus.r_en && !empty_q;

   always_comb begin
      cnt_d = cnt_q;
      if (wr_acc && !rd_acc) begin
         cnt_d = cnt_q + cnt_width'(1);
      end else if (rd_acc && !wr_acc) begin
         cnt_d = cnt_q - cnt_width'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (wr_acc) begin
         mem[wptr_q] <= bus.data_in;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_q   <= '0;
         rptr_q   <= '0;
         cnt_q    <= '0;
         dout_q   <= '0;
         dvalid_q <= 1'b0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
         afull_q  <= 1'b0;
         aempty_q <= 1'b1;
         ovf_q    <= 1'b0;
         udf_q    <= 1'b0;
      end else begin
         if (wr_acc) begin
            wptr_q <= (wptr_q == last_c) ? '0 : wptr_q + ptr_width'(1);
         end
         if (rd_acc) begin
            rptr_q <= (rptr_q == last_c) ? '0 : rptr_q + ptr_width'(1);
            dout_q <= mem[rptr_q];
         end
         dvalid_q <= rd_acc;
         cnt_q    <= cnt_d;
         // Flags come from the next count, so they move on the same edge as count.
         full_q   <= (cnt_d == depth_c);
         empty_q  <= (cnt_d == '0);
         afull_q  <= (cnt_d >= af_c);
         aempty_q <= (cnt_d <= ae_c);
         // A new error event in the same cycle as clr_err takes priority.
         if (bus.w_en && full_q) begin
            ovf_q <= 1'b1;
         end else if (bus.clr_err) begin
            ovf_q <= 1'b0;
         end
         if (bus.r_en && empty_q) begin
            udf_q <= 1'b1;
         end else if (bus.clr_err) begin
            udf_q <= 1'b0;
         end
      end
   end

   assign bus.data_out     = dout_q;
   assign bus.data_valid   = dvalid_q;
   assign bus.full         = full_q;
   assign bus.empty        = empty_q;
   assign bus.almost_full  = afull_q;
   assign bus.almost_empty = aempty_q;
   assign bus.count        = cnt_q;
   assign bus.overflow     = ovf_q;
   assign bus.underflow    = udf_q;

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
module tb_sync_fifo_ctrl;

   localparam int unsigned DW    = 8;
   localparam int unsigned DEPTH = 5;
   localparam int unsigned AF    = 4;
   localparam int unsigned AE    = 1;
   localparam int unsigned CW    = $clog2(DEPTH + 1);

   logic clk = 1'b0;
   logic rst = 1'b1;

   sync_fifo_ctrl_if #(.data_width(DW), .cnt_width(CW)) bus ();

   sync_fifo_ctrl #(
      .data_width(DW),
      .depth     (DEPTH),
      .af_thresh (AF),
      .ae_thresh (AE)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   int total  = 0;
   int passed = 0;

   // Reference model: the FIFO contents as a plain queue plus sticky error bits.
   logic [DW-1:0] model_q[$];
   logic [DW-1:0] exp_q[$];
   logic          m_ovf = 1'b0;
   logic          m_udf = 1'b0;
   logic          m_dv  = 1'b0;

   function automatic void chk(input string name, input logic [31:0] got,
                               input logic [31:0] exp);
      total++;
      if (got === exp) passed++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
   endfunction

   // Monitor: pops the scoreboard whenever the DUT presents read data.
   always @(negedge clk) begin
      if (!rst && bus.data_valid) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_data_valid", 32'(bus.data_valid), 32'd0);
         end else begin
            chk("read_data", 32'(bus.data_out), 32'(exp_q.pop_front()));
         end
      end
   end

   task automatic check_status();
      int n;
      n = model_q.size();
      chk("count", 32'(bus.count), 32'(n));
      chk("full", 32'(bus.full), 32'(n == DEPTH));
      chk("empty", 32'(bus.empty), 32'(n == 0));
      chk("almost_full", 32'(bus.almost_full), 32'(n >= AF));
      chk("almost_empty", 32'(bus.almost_empty), 32'(n <= AE));
      chk("overflow", 32'(bus.overflow), 32'(m_ovf));
      chk("underflow", 32'(bus.underflow), 32'(m_udf));
      chk("data_valid", 32'(bus.data_valid), 32'(m_dv));
   endtask

   // One clock cycle of stimulus; expected read data goes into the scoreboard.
   task automatic step(input logic w, input logic [DW-1:0] d, input logic r,
                       input logic c);
      int   n;
      logic wa, ra;
      @(negedge clk);
      bus.w_en    = w;
      bus.data_in = d;
      bus.r_en    = r;
      bus.clr_err = c;
      n  = model_q.size();
      wa = w && (n != DEPTH);
      ra = r && (n != 0);
      if (ra) exp_q.push_back(model_q.pop_front());
      if (wa) model_q.push_back(d);
      if (w && n == DEPTH) m_ovf = 1'b1;
      else if (c) m_ovf = 1'b0;
      if (r && n == 0) m_udf = 1'b1;
      else if (c) m_udf = 1'b0;
      m_dv = ra;
      @(posedge clk);
      #1;
      check_status();
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_count"}, 32'(bus.count), 32'd0);
      chk({tag, "_empty"}, 32'(bus.empty), 32'd1);
      chk({tag, "_almost_empty"}, 32'(bus.almost_empty), 32'd1);
      chk({tag, "_full"}, 32'(bus.full), 32'd0);
      chk({tag, "_almost_full"}, 32'(bus.almost_full), 32'd0);
      chk({tag, "_data_valid"}, 32'(bus.data_valid), 32'd0);
      chk({tag, "_data_out"}, 32'(bus.data_out), 32'd0);
      chk({tag, "_overflow"}, 32'(bus.overflow), 32'd0);
      chk({tag, "_underflow"}, 32'(bus.underflow), 32'd0);
   endtask

   initial begin
      bus.w_en    = 1'b0;
      bus.data_in = '0;
      bus.r_en    = 1'b0;
      bus.clr_err = 1'b0;
      repeat (2) @(negedge clk);
      check_reset_outputs("in_reset");
      rst = 1'b0;
      repeat (3) step(1'b0, 8'h00, 1'b0, 1'b0);
      chk("idle_data_out", 32'(bus.data_out), 32'd0);

      // Fill with 0x11..0x15, then drain.
      for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h11 + i), 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

      // Pointer wrap across index 4 -> 0.
      for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b0);

      // Simultaneous requests at full, then at empty.
      for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
      step(1'b1, 8'hEE, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
      step(1'b1, 8'h55, 1'b1, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b1);

      // Error clear, and set-wins-over-clear.
      for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
      step(1'b1, 8'hAA, 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b1);
      step(1'b1, 8'hBB, 1'b0, 1'b1);
      step(1'b0, 8'h00, 1'b0, 1'b1);

      // Random traffic.
      for (int i = 0; i < 400; i++) begin
         step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 9) == 0));
      end

      // Drain, refill 4, read 1 -> count 3 with data_valid high, then reset.
      for (int i = 0; i < 6; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h71 + i), 1'b0, 1'b0);
      step(1'b1, 8'h75, 1'b1, 1'b0);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("pre_reset_count", 32'(bus.count), 32'd3);
      #1;
      rst = 1'b1;
      #1;
      check_reset_outputs("async_reset");
      model_q.delete();
      exp_q.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
      m_dv  = 1'b0;
      bus.w_en = 1'b0;
      bus.r_en = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      step(1'b1, 8'h99, 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b0);
      @(negedge clk);
      #1;
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
